// File: rtl/ucsbece154b_icache.sv
// Set-associative instruction cache with round-robin replacement and a
// blocking line-fill FSM (IDLE -> REQ -> FILL -> DONE).
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadAddress_i,
    input  logic        ReadEnable_i,
    output logic [31:0] Instruction_o,
    output logic        Ready_o,
    output logic        Busy_o,
    output logic [31:0] MemReadAddress_o,
    output logic        MemReadRequest_o,
    input  logic [31:0] MemDataT_i,
    input  logic        MemDataReady_i
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W = 32 - 2 - OFF_W - SET_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:2]      pend_addr_q, pend_addr_d;
    logic             pend_valid_q, pend_valid_d;
    logic [OFF_W-1:0] beat_q, beat_d;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WAY_W-1:0]    rr_q    [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [31:0]         line_buf_q [BLOCK_WORDS];

    logic              unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ReadAddress_i[1:0]};

    logic [OFF_W-1:0] p_off;
    logic [SET_W-1:0] p_set;
    logic [TAG_W-1:0] p_tag;
    assign p_off = pend_addr_q[OFF_W+1:2];
    assign p_set = pend_addr_q[SET_W+OFF_W+1:OFF_W+2];
    assign p_tag = pend_addr_q[31:SET_W+OFF_W+2];

    logic [NUM_WAYS-1:0] way_hit;
    logic [31:0]         way_word [NUM_WAYS];
    logic                hit;
    logic [31:0]         hit_word;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_hit[gi]  = valid_q[p_set][gi] && (tag_q[p_set][gi] == p_tag);
            assign way_word[gi] = data_q[p_set][gi][p_off];
        end
    endgenerate

    assign hit = |way_hit;

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) hit_word = hit_word | way_word[w];
        end
    end

    // Prefer the lowest invalid way; only a full set consumes the pointer.
    logic [WAY_W-1:0] victim_way;
    logic             victim_invalid;
    always_comb begin
        victim_way     = rr_q[p_set];
        victim_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_invalid && !valid_q[p_set][w]) begin
                victim_way     = WAY_W'(w);
                victim_invalid = 1'b1;
            end
        end
    end

    logic sample;
    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        beat_d       = beat_q;
        sample       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_valid_q && !hit) state_d = REQ;
                else                      sample  = ReadEnable_i;
            end
            REQ:  state_d = FILL;
            FILL: begin
                if (MemDataReady_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == OFF_W'(BLOCK_WORDS - 1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                sample  = ReadEnable_i;
            end
            default: state_d = IDLE;
        endcase
        if (sample) begin
            pend_addr_d  = ReadAddress_i[31:2];
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            beat_q       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            beat_q       <= beat_d;
            if (state_q == DONE) begin
                valid_q[p_set][victim_way] <= 1'b1;
                if (!victim_invalid) rr_q[p_set] <= rr_q[p_set] + 1'b1;
            end
        end
    end

    // Storage without reset: valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (!reset && state_q == DONE) tag_q[p_set][victim_way] <= p_tag;
    end

    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (!reset && state_q == FILL && MemDataReady_i && beat_q == OFF_W'(gi))
                    line_buf_q[gi] <= MemDataT_i;
                if (!reset && state_q == DONE)
                    data_q[p_set][victim_way][gi] <= line_buf_q[gi];
            end
        end
    endgenerate

    always_comb begin
        Ready_o          = 1'b0;
        Instruction_o    = '0;
        Busy_o           = 1'b0;
        MemReadRequest_o = 1'b0;
        MemReadAddress_o = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (pend_valid_q && hit) begin
                        Ready_o       = 1'b1;
                        Instruction_o = hit_word;
                    end
                end
                REQ: begin
                    Busy_o           = 1'b1;
                    MemReadRequest_o = 1'b1;
                    MemReadAddress_o = {pend_addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                end
                FILL: Busy_o = 1'b1;
                DONE: begin
                    Ready_o       = 1'b1;
                    Instruction_o = line_buf_q[p_off];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Directed bench for ucsbece154b_icache: misses, hits, replacement,
// stalled fills, reset mid-fill and stray fill beats.
module tb_ucsbece154b_icache;

    logic        clk;
    logic        reset;
    logic [31:0] ReadAddress_i;
    logic        ReadEnable_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic        Busy_o;
    logic [31:0] MemReadAddress_o;
    logic        MemReadRequest_o;
    logic [31:0] MemDataT_i;
    logic        MemDataReady_i;

    int checks   = 0;
    int failures = 0;

    ucsbece154b_icache #(.NUM_SETS(8), .NUM_WAYS(4), .BLOCK_WORDS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ReadAddress_i    (ReadAddress_i),
        .ReadEnable_i     (ReadEnable_i),
        .Instruction_o    (Instruction_o),
        .Ready_o          (Ready_o),
        .Busy_o           (Busy_o),
        .MemReadAddress_o (MemReadAddress_o),
        .MemReadRequest_o (MemReadRequest_o),
        .MemDataT_i       (MemDataT_i),
        .MemDataReady_i   (MemDataReady_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, Ready_o}, 32'd0);
        chk({tag, "_busy"},  {31'd0, Busy_o}, 32'd0);
        chk({tag, "_req"},   {31'd0, MemReadRequest_o}, 32'd0);
        chk({tag, "_maddr"}, MemReadAddress_o, 32'd0);
        chk({tag, "_instr"}, Instruction_o, 32'd0);
    endtask

    // Presents addr, expects a miss, serves the fill with 'gap' idle cycles
    // before each beat and checks the DONE-cycle word.
    task automatic read_miss(input logic [31:0] addr, input logic [31:0] base,
                             input int gap, input logic [31:0] exp);
        ReadAddress_i = addr;
        ReadEnable_i  = 1'b1;
        tick();
        ReadEnable_i  = 1'b0;
        chk("miss_ready", {31'd0, Ready_o}, 32'd0);
        chk("miss_busy",  {31'd0, Busy_o}, 32'd0);
        tick();
        chk("req_strobe", {31'd0, MemReadRequest_o}, 32'd1);
        chk("req_addr",   MemReadAddress_o, addr & ~32'hF);
        chk("req_busy",   {31'd0, Busy_o}, 32'd1);
        tick();
        chk("fill_req_low", {31'd0, MemReadRequest_o}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("stall_busy",  {31'd0, Busy_o}, 32'd1);
                chk("stall_ready", {31'd0, Ready_o}, 32'd0);
            end
            MemDataReady_i = 1'b1;
            MemDataT_i     = base + 32'(b);
            tick();
            MemDataReady_i = 1'b0;
            MemDataT_i     = 32'd0;
            if (b < 3) chk("fill_busy", {31'd0, Busy_o}, 32'd1);
        end
        chk("done_ready", {31'd0, Ready_o}, 32'd1);
        chk("done_instr", Instruction_o, exp);
        chk("done_busy",  {31'd0, Busy_o}, 32'd0);
        $display("miss addr=%08h word=%08h", addr, Instruction_o);
        tick();
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
        ReadAddress_i = addr;
        ReadEnable_i  = 1'b1;
        tick();
        ReadEnable_i  = 1'b0;
        chk("hit_ready", {31'd0, Ready_o}, 32'd1);
        chk("hit_instr", Instruction_o, exp);
        chk("hit_busy",  {31'd0, Busy_o}, 32'd0);
        chk("hit_req",   {31'd0, MemReadRequest_o}, 32'd0);
        $display("hit  addr=%08h word=%08h", addr, Instruction_o);
    endtask

    initial begin
        reset          = 1'b1;
        ReadAddress_i  = 32'd0;
        ReadEnable_i   = 1'b0;
        MemDataT_i     = 32'd0;
        MemDataReady_i = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick();
        chk_idle_outputs("post_reset");

        // Cold miss, then hit in the same line
        read_miss(32'h0000_0008, 32'hA0, 0, 32'hA2);
        read_hit(32'h0000_000C, 32'hA3);

        // Fill all four ways of set 0, then force an eviction of way 0
        read_miss(32'h0000_0080, 32'hB0, 0, 32'hB0);
        read_miss(32'h0000_0100, 32'hC0, 0, 32'hC0);
        read_miss(32'h0000_0180, 32'hD0, 0, 32'hD0);
        read_miss(32'h0000_0200, 32'hE0, 0, 32'hE0);
        read_hit(32'h0000_0084, 32'hB1);
        read_miss(32'h0000_0000, 32'hF0, 0, 32'hF0);
        read_hit(32'h0000_0104, 32'hC1);
        read_hit(32'h0000_0208, 32'hE2);

        // Stalled fill in set 1, beats must land in order
        read_miss(32'h0000_0014, 32'h1000, 3, 32'h1001);
        read_hit(32'h0000_0010, 32'h1000);
        read_hit(32'h0000_001C, 32'h1003);

        // Reset after two beats aborts the fill
        ReadAddress_i = 32'h0000_0020;
        ReadEnable_i  = 1'b1;
        tick();
        ReadEnable_i  = 1'b0;
        tick();
        chk("rst_fill_req", {31'd0, MemReadRequest_o}, 32'd1);
        tick();
        for (int b = 0; b < 2; b++) begin
            MemDataReady_i = 1'b1;
            MemDataT_i     = 32'h5550 + 32'(b);
            tick();
        end
        MemDataReady_i = 1'b0;
        chk("rst_fill_busy", {31'd0, Busy_o}, 32'd1);
        reset = 1'b1;
        #1;
        chk_idle_outputs("during_reset");
        tick();
        reset = 1'b0;
        MemDataReady_i = 1'b1;
        MemDataT_i     = 32'h5552;
        tick();
        MemDataT_i     = 32'h5553;
        chk_idle_outputs("after_abort");
        tick();
        MemDataReady_i = 1'b0;
        chk_idle_outputs("stray_after_abort");
        read_miss(32'h0000_0020, 32'h2000, 0, 32'h2000);

        // Stray fill beat in IDLE must not disturb anything
        MemDataReady_i = 1'b1;
        MemDataT_i     = 32'h0000_DEAD;
        tick();
        tick();
        MemDataReady_i = 1'b0;
        chk("stray_ready", {31'd0, Ready_o}, 32'd1);
        chk("stray_instr", Instruction_o, 32'h2000);
        chk("stray_busy",  {31'd0, Busy_o}, 32'd0);
        chk("stray_req",   {31'd0, MemReadRequest_o}, 32'd0);
        read_hit(32'h0000_0024, 32'h2001);
        read_hit(32'h0000_0028, 32'h2002);
        read_hit(32'h0000_002C, 32'h2003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
